// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus bundle: program memory read port, IR load port and the
// controller's execute-complete / jump handshake.
interface instr_fetch_unit_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd;
    logic                  mem_rdy;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [DATA_WIDTH-1:0] ir_data;
    logic                  ir_load;
    logic                  exec_done;
    logic                  jmp_en;
    logic [ADDR_WIDTH-1:0] jmp_addr;

    // Fetch unit side
    modport master (
        output mem_addr, mem_rd, ir_data, ir_load,
        input  mem_rdy, mem_data, exec_done, jmp_en, jmp_addr
    );

    // Memory / IR / controller side
    modport slave (
        input  mem_addr, mem_rd, ir_data, ir_load,
        output mem_rdy, mem_data, exec_done, jmp_en, jmp_addr
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: owns the PC, reads program memory, hands each
// word to the IR with a one-cycle load strobe, then waits for the controller
// to finish executing it. A memory that never answers parks the unit in ERR.
module instr_fetch_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  halt,
    instr_fetch_unit_if.master    bus,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  busy,
    output logic                  fetch_err
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_LOAD,
        S_EXEC,
        S_ERR
    } state_t;

    state_t                state_reg,   state_next;
    logic [ADDR_WIDTH-1:0] pc_reg,      pc_next;
    logic [DATA_WIDTH-1:0] ir_data_reg, ir_data_next;
    logic [TW-1:0]         timer_reg,   timer_next;
    logic                  err_reg,     err_next;

    // State and datapath registers; reset wins over everything
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            pc_reg      <= '0;
            ir_data_reg <= '0;
            timer_reg   <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            ir_data_reg <= ir_data_next;
            timer_reg   <= timer_next;
            err_reg     <= err_next;
        end
    end

    // Next-state, PC update, fetch capture and timeout tracking
    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        ir_data_next = ir_data_reg;
        timer_next   = timer_reg;
        err_next     = err_reg;
        case (state_reg)
            S_IDLE: begin
                if (start && !halt) begin
                    state_next = S_REQ;
                    timer_next = '0;
                end
            end
            S_REQ: begin
                // A response in the last allowed cycle still beats the timeout
                if (bus.mem_rdy) begin
                    ir_data_next = bus.mem_data;
                    state_next   = S_LOAD;
                end else if (timer_reg == TW'(TIMEOUT - 1)) begin
                    state_next = S_ERR;
                    err_next   = 1'b1;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end
            S_LOAD: begin
                pc_next    = pc_reg + ADDR_WIDTH'(1);
                state_next = S_EXEC;
            end
            S_EXEC: begin
                if (bus.exec_done) begin
                    if (bus.jmp_en) begin
                        pc_next = bus.jmp_addr;
                    end
                    if (halt) begin
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_REQ;
                        timer_next = '0;
                    end
                end
            end
            S_ERR: begin
                err_next = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign bus.mem_addr = pc_reg;
    assign bus.mem_rd   = (state_reg == S_REQ);
    assign bus.ir_load  = (state_reg == S_LOAD);
    assign bus.ir_data  = ir_data_reg;
    assign pc           = pc_reg;
    assign busy         = (state_reg != S_IDLE) && (state_reg != S_ERR);
    assign fetch_err    = err_reg;
endmodule
